// File: rtl/uart_pkg.sv
// Shared UART types: parity mode, TX state encoding, bit-index width helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_ODD  = 2'd1,
        PAR_EVEN = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEAD,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_LAG
    } tx_state_t;

    // Bits needed to index the longest per-state bit run (floor of 2 covers two stop bits).
    function automatic int bit_idx_width(input int data_bits, input int lead_bits, input int lag_bits);
        int m;
        m = data_bits;
        if (lead_bits > m) m = lead_bits;
        if (lag_bits > m) m = lag_bits;
        if (m < 2) m = 2;
        return $clog2(m);
    endfunction

    localparam int BIT_IDX_W = bit_idx_width(8, 1, 1);

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-time generator: loads a divisor, counts it down, pulses tick on the last cycle of each bit.
// Latency: first tick div cycles after load (div of 0 behaves as 1).
// Backpressure: none; free-runs while en is high.
module uart_baud_tick #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [DIV_W-1:0] div,
    input  logic             en,
    output logic             tick
);

    logic [DIV_W-1:0] reload_q;
    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] load_val;

    assign load_val = (div == '0) ? '0 : div - DIV_W'(1);
    assign tick     = en && (cnt_q == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            reload_q <= '0;
            cnt_q    <= '0;
        end else if (load) begin
            reload_q <= load_val;
            cnt_q    <= load_val;
        end else if (en) begin
            cnt_q <= (cnt_q == '0) ? reload_q : cnt_q - DIV_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx_tristate.sv
// UART transmitter producing D/E for a tristate pad, with optional lead/lag drive around the frame.
// Latency: first line bit (lead or start) on pad_d/pad_e the cycle after accept; every bit is div_q cycles.
// Backpressure: tx_ready only in IDLE; a frame always completes before the next word is taken.
module uart_tx_tristate
    import uart_pkg::*;
#(
    parameter int DATA_BITS     = 8,
    parameter int DIV_W         = 16,
    parameter int PARITY        = 0,
    parameter int STOP_BITS     = 1,
    parameter int IDLE_TRISTATE = 1,
    parameter int LEAD_BITS     = 1,
    parameter int LAG_BITS      = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DIV_W-1:0]     baud_div,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 busy,
    output logic                 pad_d,
    output logic                 pad_e
);

    localparam int             IDX_W     = bit_idx_width(DATA_BITS, LEAD_BITS, LAG_BITS);
    localparam parity_e        PAR_MODE  = parity_e'(PARITY[1:0]);
    localparam bit             USE_LEAD  = (IDLE_TRISTATE != 0) && (LEAD_BITS > 0);
    localparam bit             USE_LAG   = (IDLE_TRISTATE != 0) && (LAG_BITS > 0);
    localparam logic           IDLE_E    = (IDLE_TRISTATE == 0);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] LEAD_LAST = IDX_W'(LEAD_BITS - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);
    localparam logic [IDX_W-1:0] LAG_LAST  = IDX_W'(LAG_BITS - 1);

    tx_state_t            state;
    logic [IDX_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;
    logic                 accept;
    logic                 tick;

    assign tx_ready = (state == ST_IDLE) && !rst;
    assign accept   = tx_valid && tx_ready;

    uart_baud_tick #(.DIV_W(DIV_W)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .load (accept),
        .div  (baud_div),
        .en   (state != ST_IDLE),
        .tick (tick)
    );

    // Outputs are assigned together with the state they belong to, so pad_d/pad_e stay registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            bit_idx <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
            busy    <= 1'b0;
            pad_d   <= 1'b1;
            pad_e   <= IDLE_E;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        shreg   <= tx_data;
                        par_bit <= (^tx_data) ^ (PAR_MODE == PAR_ODD);
                        bit_idx <= '0;
                        busy    <= 1'b1;
                        pad_e   <= 1'b1;
                        if (USE_LEAD) begin
                            state <= ST_LEAD;
                            pad_d <= 1'b1;
                        end else begin
                            state <= ST_START;
                            pad_d <= 1'b0;
                        end
                    end
                end
                ST_LEAD: begin
                    if (tick) begin
                        if (bit_idx == LEAD_LAST) begin
                            bit_idx <= '0;
                            state   <= ST_START;
                            pad_d   <= 1'b0;
                        end else begin
                            bit_idx <= bit_idx + IDX_W'(1);
                        end
                    end
                end
                ST_START: begin
                    if (tick) begin
                        state <= ST_DATA;
                        pad_d <= shreg[0];
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        if (bit_idx == DATA_LAST) begin
                            bit_idx <= '0;
                            if (PAR_MODE != PAR_NONE) begin
                                state <= ST_PARITY;
                                pad_d <= par_bit;
                            end else begin
                                state <= ST_STOP;
                                pad_d <= 1'b1;
                            end
                        end else begin
                            bit_idx <= bit_idx + IDX_W'(1);
                            shreg   <= shreg >> 1;
                            pad_d   <= shreg[1];
                        end
                    end
                end
                ST_PARITY: begin
                    if (tick) begin
                        state <= ST_STOP;
                        pad_d <= 1'b1;
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        if (bit_idx == STOP_LAST) begin
                            bit_idx <= '0;
                            if (USE_LAG) begin
                                state <= ST_LAG;
                                pad_d <= 1'b1;
                            end else begin
                                state <= ST_IDLE;
                                busy  <= 1'b0;
                                pad_d <= 1'b1;
                                pad_e <= IDLE_E;
                            end
                        end else begin
                            bit_idx <= bit_idx + IDX_W'(1);
                        end
                    end
                end
                ST_LAG: begin
                    if (tick) begin
                        if (bit_idx == LAG_LAST) begin
                            bit_idx <= '0;
                            state   <= ST_IDLE;
                            busy    <= 1'b0;
                            pad_d   <= 1'b1;
                            pad_e   <= IDLE_E;
                        end else begin
                            bit_idx <= bit_idx + IDX_W'(1);
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    pad_d <= 1'b1;
                    pad_e <= IDLE_E;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_tristate.sv
// Bench for uart_tx_tristate: four configurations checked cycle by cycle against a bit-level frame model.
module tb_uart_tx_tristate;

    typedef struct {
        int db;
        int par;
        int stop;
        int tri_st;
        int lead;
        int lag;
    } cfg_t;

    typedef struct {
        int         k;
        logic [8:0] word;
        int         div;
        int         cyc;
        logic       par;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [3:0]  tx_valid;
    logic [3:0]  tx_ready;
    logic [3:0]  busy;
    logic [3:0]  pad_d;
    logic [3:0]  pad_e;
    logic [8:0]  tx_data [4];
    logic [15:0] baud    [4];

    cfg_t       cfg [4];
    vec_t       vecs [8];
    logic [2:0] exp_q [$];
    int         par_pos;
    int         n_chk;
    int         n_pass;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 8N1, tristate idle, lead 1 / lag 1
    uart_tx_tristate #(.DATA_BITS(8), .DIV_W(16), .PARITY(0), .STOP_BITS(1),
                       .IDLE_TRISTATE(1), .LEAD_BITS(1), .LAG_BITS(1)) dut_a (
        .clk(clk), .rst(rst), .baud_div(baud[0]), .tx_data(tx_data[0][7:0]),
        .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]), .busy(busy[0]),
        .pad_d(pad_d[0]), .pad_e(pad_e[0]));

    // 8E2, tristate idle, lead 2, no lag
    uart_tx_tristate #(.DATA_BITS(8), .DIV_W(16), .PARITY(2), .STOP_BITS(2),
                       .IDLE_TRISTATE(1), .LEAD_BITS(2), .LAG_BITS(0)) dut_b (
        .clk(clk), .rst(rst), .baud_div(baud[1]), .tx_data(tx_data[1][7:0]),
        .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]), .busy(busy[1]),
        .pad_d(pad_d[1]), .pad_e(pad_e[1]));

    // 8O1, always driven
    uart_tx_tristate #(.DATA_BITS(8), .DIV_W(16), .PARITY(1), .STOP_BITS(1),
                       .IDLE_TRISTATE(0), .LEAD_BITS(1), .LAG_BITS(1)) dut_c (
        .clk(clk), .rst(rst), .baud_div(baud[2]), .tx_data(tx_data[2][7:0]),
        .tx_valid(tx_valid[2]), .tx_ready(tx_ready[2]), .busy(busy[2]),
        .pad_d(pad_d[2]), .pad_e(pad_e[2]));

    // 5N1, tristate idle, lead 1 / lag 1
    uart_tx_tristate #(.DATA_BITS(5), .DIV_W(16), .PARITY(0), .STOP_BITS(1),
                       .IDLE_TRISTATE(1), .LEAD_BITS(1), .LAG_BITS(1)) dut_d (
        .clk(clk), .rst(rst), .baud_div(baud[3]), .tx_data(tx_data[3][4:0]),
        .tx_valid(tx_valid[3]), .tx_ready(tx_ready[3]), .busy(busy[3]),
        .pad_d(pad_d[3]), .pad_e(pad_e[3]));

    task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, exp);
    endtask

    // Frame as a list of line levels, each held for max(div,1) cycles; entries are {busy, e, d}.
    task automatic build(input int k, input logic [8:0] word, input int div);
        int   lv [$];
        int   d;
        int   lead_n;
        logic p;
        d      = (div < 1) ? 1 : div;
        lead_n = (cfg[k].tri_st != 0 && cfg[k].lead > 0) ? cfg[k].lead : 0;
        for (int i = 0; i < lead_n; i++) lv.push_back(1);
        lv.push_back(0);
        for (int i = 0; i < cfg[k].db; i++) lv.push_back(int'(word[i]));
        if (cfg[k].par != 0) begin
            p = 1'b0;
            for (int i = 0; i < cfg[k].db; i++) p = p ^ word[i];
            if (cfg[k].par == 1) p = ~p;
            lv.push_back(int'(p));
        end
        for (int i = 0; i < cfg[k].stop; i++) lv.push_back(1);
        if (cfg[k].tri_st != 0) for (int i = 0; i < cfg[k].lag; i++) lv.push_back(1);
        par_pos = (lead_n + 1 + cfg[k].db) * d;
        exp_q.delete();
        foreach (lv[j]) for (int c = 0; c < d; c++) exp_q.push_back({2'b11, lv[j][0]});
    endtask

    // Called at a negedge with DUT k idle; returns at the negedge of the first idle cycle after the frame.
    task automatic send(input int k, input logic [8:0] word, input int div, input bit keep,
                        input logic [8:0] nword, input int ndiv, output int bcnt, output logic par_seen);
        logic idle_e;
        idle_e      = (cfg[k].tri_st == 0);
        tx_valid[k] = 1'b1;
        tx_data[k]  = word;
        baud[k]     = 16'(div);
        chk("ready_before_accept", k, {7'd0, tx_ready[k]}, 8'd1);
        build(k, word, div);
        @(negedge clk);
        if (keep) begin
            tx_data[k] = nword;
            baud[k]    = 16'(ndiv);
        end else begin
            tx_valid[k] = 1'b0;
        end
        bcnt     = 0;
        par_seen = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (!keep) begin
                tx_data[k] = 9'($urandom);
                baud[k]    = 16'($urandom_range(0, 9));
            end
            chk("frame_cycle", i, {5'd0, busy[k], pad_e[k], pad_d[k]}, {5'd0, exp_q[i]});
            if (busy[k]) bcnt++;
            if (i == par_pos) par_seen = pad_d[k];
            @(negedge clk);
        end
        chk("idle_outputs", k, {5'd0, busy[k], pad_e[k], pad_d[k]}, {5'd0, 1'b0, idle_e, 1'b1});
        chk("ready_after_frame", k, {7'd0, tx_ready[k]}, 8'd1);
    endtask

    initial begin
        int   bc;
        logic ps;
        n_chk  = 0;
        n_pass = 0;
        cfg[0] = '{8, 0, 1, 1, 1, 1};
        cfg[1] = '{8, 2, 2, 1, 2, 0};
        cfg[2] = '{8, 1, 1, 0, 1, 1};
        cfg[3] = '{5, 0, 1, 1, 1, 1};
        vecs[0] = '{0, 9'h0A5, 4, 48, 1'b0};
        vecs[1] = '{1, 9'h007, 3, 42, 1'b1};
        vecs[2] = '{2, 9'h007, 2, 22, 1'b0};
        vecs[3] = '{3, 9'h01F, 0,  9, 1'b0};
        vecs[4] = '{3, 9'h01F, 1,  9, 1'b0};
        vecs[5] = '{0, 9'h03C, 1, 12, 1'b0};
        vecs[6] = '{2, 9'h000, 1, 11, 1'b1};
        vecs[7] = '{1, 9'h0FF, 1, 14, 1'b0};

        rst      = 1'b1;
        tx_valid = '0;
        for (int k = 0; k < 4; k++) begin
            tx_data[k] = '0;
            baud[k]    = 16'd4;
        end
        repeat (2) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            chk("rst_busy",  k, {7'd0, busy[k]},     8'd0);
            chk("rst_pad_d", k, {7'd0, pad_d[k]},    8'd1);
            chk("rst_pad_e", k, {7'd0, pad_e[k]},    {7'd0, cfg[k].tri_st == 0});
            chk("rst_ready", k, {7'd0, tx_ready[k]}, 8'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            chk("post_rst_out", k, {5'd0, busy[k], pad_e[k], pad_d[k]}, {5'd0, 1'b0, cfg[k].tri_st == 0, 1'b1});
            chk("post_rst_ready", k, {7'd0, tx_ready[k]}, 8'd1);
        end

        for (int v = 0; v < 8; v++) begin
            send(vecs[v].k, vecs[v].word, vecs[v].div, 1'b0, 9'd0, 0, bc, ps);
            chk("busy_cycles", v, 8'(bc), 8'(vecs[v].cyc));
            if (cfg[vecs[v].k].par != 0) chk("parity_bit", v, {7'd0, ps}, {7'd0, vecs[v].par});
        end

        // Back-to-back with tx_valid held: divisor change mid-frame only affects the second frame.
        send(0, 9'h011, 4, 1'b1, 9'h022, 8, bc, ps);
        chk("b2b_first_len", 0, 8'(bc), 8'd48);
        send(0, 9'h022, 8, 1'b0, 9'd0, 0, bc, ps);
        chk("b2b_second_len", 0, 8'(bc), 8'd96);

        // Reset in the first cycle of data bit 3 (lead 4 + start 4 + bits 0..2 12 cycles).
        tx_valid[0] = 1'b1;
        tx_data[0]  = 9'h0A5;
        baud[0]     = 16'd4;
        @(negedge clk);
        tx_valid[0] = 1'b0;
        repeat (20) @(negedge clk);
        chk("mid_busy", 0, {7'd0, busy[0]}, 8'd1);
        chk("mid_bit3", 0, {7'd0, pad_d[0]}, 8'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_out", 0, {5'd0, busy[0], pad_e[0], pad_d[0]}, 8'd1);
        chk("mid_rst_ready", 0, {7'd0, tx_ready[0]}, 8'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rel_out", 0, {5'd0, busy[0], pad_e[0], pad_d[0]}, 8'd1);
        send(0, 9'h03C, 4, 1'b0, 9'd0, 0, bc, ps);
        chk("after_rst_len", 0, 8'(bc), 8'd48);

        for (int r = 0; r < 24; r++) begin
            send($urandom_range(0, 3), 9'($urandom), $urandom_range(0, 6), 1'b0, 9'd0, 0, bc, ps);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
